pcap_replay_loop_engine: RTL and testbench

//  Captures packets from the RX AXI-Stream into an on-chip replay buffer and replays them to the
//  TX AXI-Stream, either a programmed number of times or continuously until stopped.
//  It adds start/stop control, an iteration count, destination-port override and overflow-safe capture.

---
 rtl/pcap_replay_pkg.sv | 22 ++
 rtl/pcap_replay_loop_engine_out_fifo.sv | 53 +++++
 rtl/pcap_replay_loop_engine.sv | 197 +++++++++++++++++++
 tb/tb_pcap_replay_loop_engine.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcap_replay_pkg.sv
// Shared types and constants for the pcap replay loop engine.
package pcap_replay_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REPLAY = 2'd1,
    ST_DRAIN  = 2'd2
  } state_e;

  localparam int TUSER_LEN_LSB = 0;
  localparam int TUSER_SRC_LSB = 16;
  localparam int TUSER_DST_LSB = 24;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/pcap_replay_loop_engine_out_fifo.sv
// 2-entry first-word-fall-through output FIFO; almost_full counts the read in flight.
module replay_out_fifo #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_srst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  input  logic         i_pend,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic         o_afull
);

  logic [W-1:0] r_mem [2];
  logic         r_wp, r_rp;
  logic [1:0]   r_cnt;
  logic         w_pop;
  logic [2:0]   w_occ;

  assign o_valid = (r_cnt != 2'd0);
  assign o_data  = r_mem[r_rp];
  assign w_pop   = o_valid && i_ready;
  // Occupancy next cycle if the reader issues nothing more now.
  assign w_occ   = {1'b0, r_cnt} + {2'b0, i_pend} - {2'b0, w_pop};
  assign o_afull = (w_occ >= 3'd2);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
      r_cnt    <= 2'd0;
    end else if (i_srst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wp] <= i_data;
        r_wp        <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      r_cnt <= r_cnt + {1'b0, i_push} - {1'b0, w_pop};
    end
  end

endmodule

// File: rtl/pcap_replay_loop_engine.sv
// Captures RX packets into a replay buffer and loops them out on TX with
// iteration count, stop control and optional tuser dst-port override.
module pcap_replay_loop_engine
  import pcap_replay_pkg::*;
#(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int BUF_DEPTH            = 1024,
  parameter int DST_PORT_LSB         = TUSER_DST_LSB,
  parameter int ITER_WIDTH           = 32
) (
  input  logic                              axi_aclk,
  input  logic                              axi_aresetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  input  logic                              s_axis_tlast,
  output logic                              s_axis_tready,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_tready,
  input  logic                              sw_rst,
  input  logic                              cfg_start,
  input  logic                              cfg_stop,
  input  logic                              cfg_clear,
  input  logic [ITER_WIDTH-1:0]             cfg_iterations,
  input  logic                              cfg_dst_ovr_en,
  input  logic [7:0]                        cfg_dst_port,
  output logic [clog2(BUF_DEPTH):0]         stat_words,
  output logic [31:0]                       stat_pkts,
  output logic [ITER_WIDTH-1:0]             stat_iter,
  output logic                              stat_active,
  output logic                              stat_overflow
);

  localparam int DW = C_S_AXIS_DATA_WIDTH;
  localparam int SW = DW / 8;
  localparam int TW = C_S_AXIS_TUSER_WIDTH;
  localparam int WW = DW + SW + TW + 1;
  localparam int AW = clog2(BUF_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(BUF_DEPTH);

  state_e              r_state;
  logic [WW-1:0]       r_mem [BUF_DEPTH];
  logic                r_last_mem [BUF_DEPTH];
  logic [PW-1:0]       r_wr_ptr, r_commit_ptr, r_rd_ptr;
  logic [31:0]         r_pkts;
  logic                r_ovf, r_in_pkt, r_drop;
  logic [ITER_WIDTH-1:0] r_iter;
  logic                r_open, r_rd_vld;
  logic [WW-1:0]       r_ram_q;

  logic                w_rx_acc, w_full, w_clear, w_in_pkt_nxt, w_wr_en;
  logic                w_start, w_issue, w_last_addr, w_pass_end;
  logic                w_afull, w_tx_vld;
  logic [WW-1:0]       w_push_data, w_fifo_q;
  logic [AW-1:0]       w_rd_addr;

  assign s_axis_tready = (r_state == ST_IDLE);
  assign w_rx_acc      = s_axis_tvalid && s_axis_tready;
  assign w_full        = (r_wr_ptr == DEPTH_P);
  assign w_clear       = cfg_clear && (r_state == ST_IDLE);
  assign w_in_pkt_nxt  = w_rx_acc ? !s_axis_tlast : r_in_pkt;
  assign w_wr_en       = w_rx_acc && !w_clear && !r_drop && !w_full;

  assign w_start     = (r_state == ST_IDLE) && cfg_start && !cfg_stop && !cfg_clear &&
                       (r_commit_ptr != '0) && !r_in_pkt;
  assign w_rd_addr   = r_rd_ptr[AW-1:0];
  assign w_last_addr = (r_rd_ptr == r_commit_ptr - PW'(1));
  // After a stop, keep fetching only while the last fetched word left a packet open.
  assign w_issue     = !w_afull && ((r_state == ST_REPLAY) || ((r_state == ST_DRAIN) && r_open));
  assign w_pass_end  = w_issue && w_last_addr;

  always_ff @(posedge axi_aclk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[AW-1:0]]      <= {s_axis_tlast, s_axis_tuser, s_axis_tstrb, s_axis_tdata};
      r_last_mem[r_wr_ptr[AW-1:0]] <= s_axis_tlast;
    end
    if (w_issue) r_ram_q <= r_mem[w_rd_addr];
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_pkts       <= '0;
      r_ovf        <= 1'b0;
      r_in_pkt     <= 1'b0;
      r_drop       <= 1'b0;
    end else if (sw_rst) begin
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_pkts       <= '0;
      r_ovf        <= 1'b0;
      r_in_pkt     <= 1'b0;
      r_drop       <= 1'b0;
    end else begin
      r_in_pkt <= w_in_pkt_nxt;
      if (w_clear) begin
        r_wr_ptr     <= '0;
        r_commit_ptr <= '0;
        r_pkts       <= '0;
        r_ovf        <= 1'b0;
        r_drop       <= w_in_pkt_nxt;
      end else if (w_rx_acc) begin
        if (r_drop) begin
          r_drop <= !s_axis_tlast;
        end else if (w_full) begin
          r_wr_ptr <= r_commit_ptr;
          r_ovf    <= 1'b1;
          r_drop   <= !s_axis_tlast;
        end else begin
          r_wr_ptr <= r_wr_ptr + PW'(1);
          if (s_axis_tlast) begin
            r_commit_ptr <= r_wr_ptr + PW'(1);
            r_pkts       <= r_pkts + 32'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_state  <= ST_IDLE;
      r_rd_ptr <= '0;
      r_iter   <= '0;
      r_open   <= 1'b0;
      r_rd_vld <= 1'b0;
    end else if (sw_rst) begin
      r_state  <= ST_IDLE;
      r_rd_ptr <= '0;
      r_iter   <= '0;
      r_open   <= 1'b0;
      r_rd_vld <= 1'b0;
    end else begin
      r_rd_vld <= w_issue;
      if (w_issue) begin
        r_rd_ptr <= w_last_addr ? '0 : r_rd_ptr + PW'(1);
        r_open   <= !r_last_mem[w_rd_addr];
      end
      case (r_state)
        ST_IDLE: if (w_start) begin
          r_state  <= ST_REPLAY;
          r_iter   <= '0;
          r_rd_ptr <= '0;
          r_open   <= 1'b0;
        end
        // A stopped pass is not counted as completed.
        ST_REPLAY: if (cfg_stop) begin
          r_state <= ST_DRAIN;
        end else if (w_pass_end) begin
          r_iter <= r_iter + ITER_WIDTH'(1);
          if ((cfg_iterations != '0) && (r_iter + ITER_WIDTH'(1) == cfg_iterations))
            r_state <= ST_DRAIN;
        end
        ST_DRAIN: if (!r_open && !r_rd_vld && !w_tx_vld) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_push_data = r_ram_q;
    if (cfg_dst_ovr_en) w_push_data[DW + SW + DST_PORT_LSB +: 8] = cfg_dst_port;
  end

  replay_out_fifo #(.W(WW)) u_out_fifo (
    .i_clk   (axi_aclk),
    .i_rst_n (axi_aresetn),
    .i_srst  (sw_rst),
    .i_push  (r_rd_vld),
    .i_data  (w_push_data),
    .i_ready (m_axis_tready),
    .i_pend  (r_rd_vld),
    .o_valid (w_tx_vld),
    .o_data  (w_fifo_q),
    .o_afull (w_afull)
  );

  assign m_axis_tvalid = w_tx_vld;
  assign {m_axis_tlast, m_axis_tuser, m_axis_tstrb, m_axis_tdata} = w_fifo_q;

  assign stat_words    = r_commit_ptr;
  assign stat_pkts     = r_pkts;
  assign stat_iter     = r_iter;
  assign stat_active   = (r_state != ST_IDLE);
  assign stat_overflow = r_ovf;

endmodule

// File: tb/tb_pcap_replay_loop_engine.sv
// Randomized bench for pcap_replay_loop_engine against a queue-based replay model.
module tb_pcap_replay_loop_engine;

  localparam int DW = 64, TW = 64, DEPTH = 8;

  logic          axi_aclk = 1'b0, axi_aresetn = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic [7:0]    s_axis_tstrb = '0;
  logic [TW-1:0] s_axis_tuser = '0;
  logic          s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0, s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [7:0]    m_axis_tstrb;
  logic [TW-1:0] m_axis_tuser;
  logic          m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic          sw_rst = 1'b0, cfg_start = 1'b0, cfg_stop = 1'b0, cfg_clear = 1'b0;
  logic [31:0]   cfg_iterations = '0;
  logic          cfg_dst_ovr_en = 1'b0;
  logic [7:0]    cfg_dst_port = '0;
  logic [3:0]    stat_words;
  logic [31:0]   stat_pkts, stat_iter;
  logic          stat_active, stat_overflow;

  pcap_replay_loop_engine #(
    .C_M_AXIS_DATA_WIDTH(DW), .C_S_AXIS_DATA_WIDTH(DW),
    .C_M_AXIS_TUSER_WIDTH(TW), .C_S_AXIS_TUSER_WIDTH(TW),
    .BUF_DEPTH(DEPTH), .DST_PORT_LSB(24), .ITER_WIDTH(32)
  ) dut (
    .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tstrb(s_axis_tstrb), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .sw_rst(sw_rst), .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_clear(cfg_clear),
    .cfg_iterations(cfg_iterations), .cfg_dst_ovr_en(cfg_dst_ovr_en), .cfg_dst_port(cfg_dst_port),
    .stat_words(stat_words), .stat_pkts(stat_pkts), .stat_iter(stat_iter),
    .stat_active(stat_active), .stat_overflow(stat_overflow)
  );

  initial forever #5 axi_aclk = ~axi_aclk;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  s;
    logic [63:0] u;
    logic        l;
  } word_t;

  word_t mdl_buf[$];
  word_t rx_q[$];
  int    mdl_pkts = 0;
  bit    mdl_ovf = 0;
  int    total = 0, bad = 0;
  bit    tx_rand = 0;
  bit    prev_stall = 0;
  word_t prev_w;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // TX monitor: collects handshaken words and checks fields hold while stalled.
  always @(negedge axi_aclk) begin
    word_t w;
    w.d = m_axis_tdata; w.s = m_axis_tstrb; w.u = m_axis_tuser; w.l = m_axis_tlast;
    if (m_axis_tvalid) begin
      if (prev_stall) begin
        chk("hold_d", w.d, prev_w.d);
        chk("hold_u", w.u, prev_w.u);
        chk("hold_l", w.l, prev_w.l);
      end
      if (m_axis_tready) rx_q.push_back(w);
      prev_stall = !m_axis_tready;
      prev_w = w;
    end else begin
      prev_stall = 0;
    end
  end

  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge axi_aclk); #1;
      m_axis_tready = tx_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic step();
    @(posedge axi_aclk); #1;
  endtask

  task automatic mdl_reset();
    mdl_buf.delete(); mdl_pkts = 0; mdl_ovf = 0;
  endtask

  task automatic chk_stats();
    chk("words", stat_words, mdl_buf.size());
    chk("pkts", stat_pkts, mdl_pkts);
    chk("ovf", stat_overflow, mdl_ovf);
  endtask

  task automatic send_pkt(input int len, input bit fix, input logic [63:0] fu);
    word_t p[$];
    for (int i = 0; i < len; i++) begin
      word_t w;
      w.d = {$urandom, $urandom};
      w.s = 8'($urandom);
      w.u = fix ? fu : {$urandom, $urandom};
      w.l = (i == len - 1);
      s_axis_tdata = w.d; s_axis_tstrb = w.s; s_axis_tuser = w.u;
      s_axis_tlast = w.l; s_axis_tvalid = 1'b1;
      @(negedge axi_aclk);
      chk("rx_rdy", s_axis_tready, 1);
      step();
      p.push_back(w);
    end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    if (mdl_buf.size() + len > DEPTH) mdl_ovf = 1;
    else begin
      foreach (p[i]) mdl_buf.push_back(p[i]);
      mdl_pkts++;
    end
  endtask

  task automatic clear_buf();
    cfg_clear = 1'b1; step(); cfg_clear = 1'b0; step();
    mdl_reset();
    chk_stats();
  endtask

  task automatic pulse_start();
    cfg_start = 1'b1; step(); cfg_start = 1'b0;
  endtask

  task automatic wait_idle();
    int cyc = 0;
    while (stat_active && cyc < 300) begin @(negedge axi_aclk); cyc++; end
    chk("idle_to", cyc < 300, 1);
    repeat (4) @(negedge axi_aclk);
  endtask

  task automatic do_replay(input int iters, input bit ovr, input logic [7:0] port);
    word_t exp[$];
    int lat, cyc;
    cfg_iterations = iters; cfg_dst_ovr_en = ovr; cfg_dst_port = port;
    for (int p = 0; p < iters; p++)
      foreach (mdl_buf[i]) begin
        word_t e = mdl_buf[i];
        if (ovr) e.u[31:24] = port;
        exp.push_back(e);
      end
    rx_q.delete();
    pulse_start();
    lat = 0;
    do begin @(negedge axi_aclk); lat++; end while (!m_axis_tvalid && lat < 20);
    chk("latency", lat <= 3, 1);
    cyc = 0;
    while (rx_q.size() < exp.size() && cyc < 3000) begin @(negedge axi_aclk); cyc++; end
    chk("tx_to", cyc < 3000, 1);
    if (!tx_rand) chk("rate", cyc <= exp.size() + 1, 1);
    wait_idle();
    chk("active", stat_active, 0);
    chk("ntx", rx_q.size(), exp.size());
    chk("iter", stat_iter, iters);
    for (int i = 0; i < exp.size() && i < rx_q.size(); i++) begin
      chk($sformatf("d%0d", i), rx_q[i].d, exp[i].d);
      chk($sformatf("s%0d", i), rx_q[i].s, exp[i].s);
      chk($sformatf("u%0d", i), rx_q[i].u, exp[i].u);
      chk($sformatf("l%0d", i), rx_q[i].l, exp[i].l);
    end
    step();
  endtask

  initial begin
    int cyc;
    int lpos[6];
    word_t w;
    lpos = '{1, 2, 5, 7, 8, 11};
    repeat (2) @(negedge axi_aclk);
    chk("rst_rdy", s_axis_tready, 1);
    chk("rst_vld", m_axis_tvalid, 0);
    step(); axi_aresetn = 1'b1; step();
    chk("rst_data", m_axis_tdata, 0);
    chk("rst_act", stat_active, 0);
    chk("rst_iter", stat_iter, 0);
    chk_stats();

    // 2,1,3-word packets replayed twice, then again with TX back-pressure
    send_pkt(2, 0, 0); send_pkt(1, 0, 0); send_pkt(3, 0, 0);
    chk_stats();
    do_replay(2, 0, 0);
    if (rx_q.size() == 12) foreach (lpos[k]) chk("tlast_pos", rx_q[lpos[k]].l, 1);
    tx_rand = 1; do_replay(2, 0, 0); tx_rand = 0;

    // overflow: second 5-word packet cannot fit in 8 words
    clear_buf();
    send_pkt(5, 0, 0); send_pkt(5, 0, 0);
    chk("ovf_words", stat_words, 5);
    chk("ovf_pkts", stat_pkts, 1);
    chk("ovf_flag", stat_overflow, 1);
    chk_stats();

    // infinite replay stopped during word 2 of pass 3
    clear_buf();
    send_pkt(4, 0, 0);
    cfg_iterations = 0; cfg_dst_ovr_en = 0;
    rx_q.delete();
    pulse_start();
    cyc = 0;
    while (rx_q.size() < 9 && cyc < 500) begin @(posedge axi_aclk); cyc++; end
    chk("stop_to", cyc < 500, 1);
    #1 cfg_stop = 1'b1; step(); cfg_stop = 1'b0;
    wait_idle();
    chk("stop_ntx", rx_q.size(), 12);
    chk("stop_iter", stat_iter, 2);
    for (int i = 0; i < rx_q.size(); i++) begin
      chk($sformatf("stop_d%0d", i), rx_q[i].d, mdl_buf[i % 4].d);
      chk($sformatf("stop_l%0d", i), rx_q[i].l, (i % 4) == 3);
    end
    step();

    // dst-port override
    clear_buf();
    send_pkt(1, 1, 64'h0000_0000_0102_0040);
    do_replay(1, 1, 8'h04);
    if (rx_q.size() == 1) begin
      w = rx_q[0];
      chk("ovr_user", w.u[31:0], 32'h0402_0040);
    end

    // randomized rounds
    for (int r = 0; r < 6; r++) begin
      int n;
      clear_buf();
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) send_pkt($urandom_range(1, 4), 0, 0);
      chk_stats();
      tx_rand = 1'($urandom_range(0, 1));
      do_replay($urandom_range(1, 3), 1'($urandom_range(0, 1)), 8'($urandom));
      tx_rand = 0;
    end

    // start with empty buffer is ignored
    clear_buf();
    pulse_start();
    repeat (5) step();
    chk("empty_act", stat_active, 0);
    chk("empty_vld", m_axis_tvalid, 0);

    // async reset mid-replay
    send_pkt(3, 0, 0);
    cfg_iterations = 0;
    pulse_start();
    cyc = 0;
    while (rx_q.size() < 4 && cyc < 500) begin @(posedge axi_aclk); cyc++; end
    rx_q.delete();
    cyc = 0;
    while (rx_q.size() < 4 && cyc < 500) begin @(posedge axi_aclk); cyc++; end
    chk("ar_to", cyc < 500, 1);
    #1 axi_aresetn = 1'b0;
    #1 chk("ar_vld", m_axis_tvalid, 0);
    chk("ar_act", stat_active, 0);
    chk("ar_rdy", s_axis_tready, 1);
    step(); axi_aresetn = 1'b1; step();
    mdl_reset();
    chk("ar_words", stat_words, 0);
    chk("ar_iter", stat_iter, 0);
    chk_stats();

    // software reset mid-replay, one cycle later
    send_pkt(3, 0, 0);
    pulse_start();
    rx_q.delete();
    cyc = 0;
    while (rx_q.size() < 4 && cyc < 500) begin @(posedge axi_aclk); cyc++; end
    chk("sr_to", cyc < 500, 1);
    #1 sw_rst = 1'b1;
    @(negedge axi_aclk);
    chk("sr_hold", m_axis_tvalid, 1);
    step(); sw_rst = 1'b0;
    mdl_reset();
    chk("sr_vld", m_axis_tvalid, 0);
    chk("sr_act", stat_active, 0);
    chk("sr_rdy", s_axis_tready, 1);
    chk_stats();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
